// File: rtl/ov5640_cfg_seq.sv
// ov5640_cfg_seq
// Power-up and register-initialisation sequencer for the OV5640 sensor.
// It sequences the PWDN/RESET pins through the power-up timing, then walks
// an external configuration ROM of {addr16, data8} entries and issues each
// entry as an SCCB write through a request/done handshake. Entries whose
// address is 16'hFFFF are delays of data[7:0] ms instead of writes.
//
// Build option: define OV5640_CFG_READBACK_EN to read every written register
// back. A read NACK or a data mismatch then counts as a failed attempt, and
// the write/read pair is retried from the same retry budget.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               one-cycle pulse, (re)starts from IDLE/DONE/FAIL
//   cfg_idx / cfg_data  ROM address out / ROM word in (valid 1 cycle later)
//   sccb_req/rd/addr/wdata  request to the shared SCCB master
//   sccb_ack/done/err/rdata responses from the SCCB master
//   cam_pwdn, cam_rst_n camera power-down and reset pins
//   busy, cfg_done, cfg_err, err_idx  sequence status
`timescale 1ns/1ps
module ov5640_cfg_seq #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int CFG_NUM     = 252,
  parameter int PWDN_MS     = 5,
  parameter int RST_MS      = 1,
  parameter int BOOT_MS     = 20,
  parameter int RETRY_MAX   = 3,
  parameter int AUTO_START  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [9:0]  cfg_idx,
  input  logic [23:0] cfg_data,
  output logic        sccb_req,
  output logic        sccb_rd,
  output logic [15:0] sccb_addr,
  output logic [7:0]  sccb_wdata,
  input  logic        sccb_ack,
  input  logic        sccb_done,
  input  logic        sccb_err,
  input  logic [7:0]  sccb_rdata,
  output logic        cam_pwdn,
  output logic        cam_rst_n,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [9:0]  err_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWDN, S_RST, S_BOOT, S_FETCH, S_ISSUE,
    S_WAIT, S_DLY, S_NEXT, S_DONE, S_FAIL
  } state_t;

  localparam logic [31:0] TICK_LAST = 32'(CLK_FREQ_HZ / 1000 - 1);
  localparam logic [15:0] PWDN_T    = 16'(PWDN_MS);
  localparam logic [15:0] RST_T     = 16'(RST_MS);
  localparam logic [15:0] BOOT_T    = 16'(BOOT_MS);
  localparam logic [9:0]  CFG_LAST  = 10'(CFG_NUM - 1);
  localparam logic [7:0]  RETRY_LIM = 8'(RETRY_MAX);
  localparam logic        AUTO      = (AUTO_START != 0);

  state_t      state;
  logic [31:0] cyc_cnt;
  logic [15:0] ms_cnt;
  logic [7:0]  dly_ms;
  logic [7:0]  retries;
  logic        auto_pend;
  logic        xfer_bad;

`ifdef OV5640_CFG_READBACK_EN
  logic rd_phase;
  assign xfer_bad = sccb_err || (rd_phase && (sccb_rdata != sccb_wdata));
`else
  logic unused_rdata;
  assign xfer_bad     = sccb_err;
  assign unused_rdata = ^sccb_rdata;
`endif

  // True on the last cycle of an n-ms interval measured from state entry;
  // a zero-length interval still occupies the one cycle spent in the state.
  function automatic logic expired(input logic [15:0] n);
    return (n == 16'd0) || ((cyc_cnt == TICK_LAST) && (ms_cnt == n - 16'd1));
  endfunction

  // Every state entry restarts the ms timer so each delay is exact.
  task automatic enter(input state_t s);
    state   <= s;
    cyc_cnt <= '0;
    ms_cnt  <= '0;
  endtask

  // Outcome of a completed SCCB transaction (from WAIT, or from ISSUE when
  // ack and done coincide).
  task automatic xfer_end();
    if (xfer_bad) begin
`ifdef OV5640_CFG_READBACK_EN
      rd_phase <= 1'b0;
`endif
      sccb_rd <= 1'b0;
      if (retries < RETRY_LIM) begin
        retries  <= retries + 8'd1;
        sccb_req <= 1'b1;
        enter(S_ISSUE);
      end else begin
        cfg_err <= 1'b1;
        err_idx <= cfg_idx;
        busy    <= 1'b0;
        enter(S_FAIL);
      end
    end else begin
`ifdef OV5640_CFG_READBACK_EN
      if (!rd_phase) begin
        rd_phase <= 1'b1;
        sccb_rd  <= 1'b1;
        sccb_req <= 1'b1;
        enter(S_ISSUE);
      end else begin
        rd_phase <= 1'b0;
        sccb_rd  <= 1'b0;
        enter(S_NEXT);
      end
`else
      enter(S_NEXT);
`endif
    end
  endtask

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      ms_cnt     <= '0;
      dly_ms     <= '0;
      retries    <= '0;
      auto_pend  <= 1'b1;
      cam_pwdn   <= 1'b1;
      cam_rst_n  <= 1'b0;
      sccb_req   <= 1'b0;
      sccb_rd    <= 1'b0;
      sccb_addr  <= '0;
      sccb_wdata <= '0;
      cfg_idx    <= '0;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      err_idx    <= '0;
`ifdef OV5640_CFG_READBACK_EN
      rd_phase   <= 1'b0;
`endif
    end else begin
      auto_pend <= 1'b0;
      if (cyc_cnt == TICK_LAST) begin
        cyc_cnt <= '0;
        ms_cnt  <= ms_cnt + 16'd1;
      end else begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end

      case (state)
        // auto_pend is only set on the first cycle after reset, in IDLE.
        S_IDLE, S_DONE, S_FAIL: begin
          if (start || (AUTO && auto_pend)) begin
            busy      <= 1'b1;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_idx   <= '0;
            retries   <= '0;
            cam_pwdn  <= 1'b1;
            cam_rst_n <= 1'b0;
            enter(S_PWDN);
          end
        end
        S_PWDN: if (expired(PWDN_T)) begin
          cam_pwdn <= 1'b0;
          enter(S_RST);
        end
        S_RST: if (expired(RST_T)) begin
          cam_rst_n <= 1'b1;
          enter(S_BOOT);
        end
        S_BOOT: if (expired(BOOT_T)) enter(S_FETCH);
        // cfg_idx has been stable for one cycle here, so cfg_data is valid.
        S_FETCH: begin
          if (cfg_data[23:8] == 16'hFFFF) begin
            dly_ms <= cfg_data[7:0];
            enter(S_DLY);
          end else begin
            sccb_addr  <= cfg_data[23:8];
            sccb_wdata <= cfg_data[7:0];
            sccb_rd    <= 1'b0;
            sccb_req   <= 1'b1;
            enter(S_ISSUE);
          end
        end
        S_ISSUE: if (sccb_ack) begin
          sccb_req <= 1'b0;
          if (sccb_done) xfer_end();
          else           enter(S_WAIT);
        end
        S_WAIT: if (sccb_done) xfer_end();
        S_DLY:  if (expired({8'd0, dly_ms})) enter(S_NEXT);
        S_NEXT: begin
          retries <= '0;
          if (cfg_idx == CFG_LAST) begin
            cfg_done <= 1'b1;
            busy     <= 1'b0;
            enter(S_DONE);
          end else begin
            cfg_idx <= cfg_idx + 10'd1;
            enter(S_FETCH);
          end
        end
        default: enter(S_IDLE);
      endcase
    end
  end

endmodule

// File: doc/ov5640_cfg_seq.md
Name: ov5640_cfg_seq

Overview:
- Power-up and register-initialisation sequencer for the OV5640 camera front end, i.e. the sensor whose sync/pixel signals feed the capture datapath and its on-chip debug probes.
- Drives the camera PWDN/RESET pins through the datasheet power-up timing.
- Walks an external configuration ROM of {addr16, data8} entries and issues each as a write to a shared SCCB master through a request/done handshake.
- Reports done/error to the system so the pixel capture path can be enabled.

Parameters:
- CLK_FREQ_HZ, 50000000, clk frequency; sets the 1 ms tick divider (CLK_FREQ_HZ/1000 cycles per tick).
- CFG_NUM, 252, number of ROM entries (1..1023).
- PWDN_MS, 5, ms that cam_pwdn is held high after start.
- RST_MS, 1, ms that cam_rst_n is held low after cam_pwdn falls.
- BOOT_MS, 20, ms waited after cam_rst_n rises before the first SCCB access.
- RETRY_MAX, 3, extra attempts per entry after an SCCB error.
- AUTO_START, 1, when 1 the sequence starts by itself on the first cycle after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; starts or restarts the sequence from IDLE, DONE or FAIL
- cfg_idx  out  10  ROM address
- cfg_data  in  24  ROM data {addr[23:8], data[7:0]}; valid 1 cycle after cfg_idx changes
- sccb_req  out  1  request valid
- sccb_rd  out  1  1 = read, 0 = write; qualifies sccb_req
- sccb_addr  out  16  register address
- sccb_wdata  out  8  write data
- sccb_ack  in  1  master accepted the request (single-cycle pulse)
- sccb_done  in  1  transaction complete (single-cycle pulse)
- sccb_err  in  1  NACK; valid with sccb_done
- sccb_rdata  in  8  read data; valid with sccb_done
- cam_pwdn  out  1  camera power-down pin
- cam_rst_n  out  1  camera reset pin
- busy  out  1  sequence in progress
- cfg_done  out  1  level; all entries written
- cfg_err  out  1  level; an entry failed after all retries
- err_idx  out  10  index of the failing entry

Behaviour:
- Reset values: cam_pwdn=1, cam_rst_n=0, sccb_req=0, sccb_rd=0, sccb_addr=0, sccb_wdata=0, cfg_idx=0, busy=0, cfg_done=0, cfg_err=0, err_idx=0; state=IDLE. Reset asserted mid-transaction aborts immediately with these values.
- ms tick: free-running counter, cleared on every state entry, so every delay is exact: N ms = N*CLK_FREQ_HZ/1000 cycles.
- IDLE -> PWDN: on start, or on the first cycle after reset when AUTO_START=1. busy=1; clear cfg_done, cfg_err, cfg_idx.
- PWDN: cam_pwdn=1, cam_rst_n=0 for PWDN_MS -> RST.
- RST: cam_pwdn=0, cam_rst_n=0 for RST_MS -> BOOT.
- BOOT: cam_rst_n=1 for BOOT_MS -> FETCH.
- FETCH: one-cycle ROM latency; latch cfg_data.
  - Latched addr == 16'hFFFF: delay entry, go to DLY for data[7:0] ms; data=0 takes 1 cycle.
  - Otherwise -> ISSUE.
- ISSUE: hold sccb_req=1 with sccb_addr/sccb_wdata/sccb_rd stable until sccb_ack is sampled high; drop sccb_req the cycle after -> WAIT.
- WAIT: on sccb_done:
  - sccb_err=0 -> NEXT.
  - sccb_err=1 and retries < RETRY_MAX -> retries+1, back to ISSUE.
  - sccb_err=1 and retries exhausted -> FAIL.
- sccb_ack and sccb_done arriving in the same cycle: treated as ack then done; proceed straight to the done handling.
- DLY -> NEXT when its delay expires.
- NEXT: retries=0.
  - cfg_idx==CFG_NUM-1 -> DONE.
  - Otherwise cfg_idx+1 -> FETCH.
- DONE: cfg_done=1, busy=0; holds until start or rst.
- FAIL: cfg_err=1, err_idx=cfg_idx, busy=0; camera pins keep their current levels; holds until start or rst.
- start while busy is ignored.
- sccb_done arriving outside WAIT is ignored.
- Per-entry latency with an ideal master: 1 FETCH + ISSUE-to-ack + ack-to-done + 1 NEXT cycle.

Optional Feature:
- Macro: OV5640_CFG_READBACK_EN.
- Defined: after each successful write, the block issues a read of the same address (sccb_rd=1, same handshake).
  - sccb_rdata != written data, or sccb_err on the read, counts as one failed attempt.
  - A failed attempt retries the write/read pair, sharing the RETRY_MAX budget.
  - Delay entries are not read back.
- Undefined: sccb_rd is constant 0 and sccb_rdata is ignored.

Test Plan:
- CLK_FREQ_HZ=10000 (10 cycles/ms), CFG_NUM=3, ideal master (ack 1 cycle after req, done 5 cycles later) -> cam_pwdn falls at cycle 50, cam_rst_n rises 10 cycles later, first sccb_req 200 cycles after that; 3 writes in ROM order; cfg_done=1, busy=0.
- Entry 1 = {16'hFFFF, 8'd4} -> no sccb_req for exactly 40 cycles between the writes of entries 0 and 2.
- Master NACKs entry 2 twice, then accepts (RETRY_MAX=3) -> 3 requests for entry 2, cfg_done=1, cfg_err=0.
- Master NACKs entry 1 four times -> cfg_err=1, err_idx=1, entry 2 never requested, cfg_done=0.
- rst pulsed while sccb_req=1 -> next cycle all outputs at reset values; with AUTO_START=1 the full sequence restarts from PWDN.
- With OV5640_CFG_READBACK_EN defined, readback returns 8'h00 for written 8'h11 on every attempt -> 4 write/read pairs, cfg_err=1, err_idx=0.
